// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter slice.
// Holds the sequencer state encoding and memory word definitions.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        RSP
    } arb_state_t;

    localparam int MEM_AW = 16;
    localparam int MEM_DW = 16;

    typedef logic [15:0] mem_word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// Searches upward from ptr+1, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_id
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        idx    = 0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = (int'(ptr) + i) % NREQ;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_id   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin sequencer sharing one single-port memory.
// One transaction in flight: accept, access, respond.
module memory_arbiter #(
    parameter int NREQ   = 2,
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_wr,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*DW-1:0]       req_wdata,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DW-1:0]            rsp_rdata,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wr_data,
    output logic                     mem_rd,
    output logic                     mem_wr,
    input  logic [DW-1:0]            mem_data_in,
    output logic [$clog2(NREQ)-1:0]  grant_id
);

    import mem_arb_pkg::*;

    localparam int IW = $clog2(NREQ);
    localparam logic [3:0] LAT = 4'(RD_LAT);

    arb_state_t state, state_nx;
    logic [IW-1:0] ptr, ptr_nx;
    logic [3:0] cnt, cnt_nx;

    logic [NREQ-1:0] pick;
    logic [IW-1:0] pick_id;

    logic [IW-1:0] gid_nx;
    logic [AW-1:0] addr_nx;
    logic [DW-1:0] wdata_nx;
    logic [DW-1:0] rdata_nx;
    logic [NREQ-1:0] rsp_nx;
    logic rd_nx;
    logic wr_nx;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt    (pick),
        .gnt_id (pick_id)
    );

    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        cnt_nx    = cnt;
        gid_nx    = grant_id;
        addr_nx   = mem_addr;
        wdata_nx  = mem_wr_data;
        rdata_nx  = rsp_rdata;
        rsp_nx    = '0;
        rd_nx     = 1'b0;
        wr_nx     = 1'b0;
        req_ready = '0;
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = pick;
                    ptr_nx    = pick_id;
                    gid_nx    = pick_id;
                    addr_nx   = req_addr[pick_id*AW +: AW];
                    wdata_nx  = req_wdata[pick_id*DW +: DW];
                    if (req_wr[pick_id]) begin
                        state_nx = WR;
                        wr_nx    = 1'b1;
                    end else begin
                        state_nx = RD;
                        rd_nx    = 1'b1;
                        cnt_nx   = 4'd1;
                    end
                end
            end
            WR: begin
                state_nx         = RSP;
                rsp_nx[grant_id] = 1'b1;
            end
            RD: begin
                // cnt holds the number of mem_rd cycles already shown
                if (cnt == LAT) begin
                    state_nx         = RSP;
                    rdata_nx         = mem_data_in;
                    rsp_nx[grant_id] = 1'b1;
                end else begin
                    rd_nx  = 1'b1;
                    cnt_nx = cnt + 4'd1;
                end
            end
            RSP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= IW'(NREQ - 1);
            cnt         <= '0;
            grant_id    <= '0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            cnt         <= cnt_nx;
            grant_id    <= gid_nx;
            mem_addr    <= addr_nx;
            mem_wr_data <= wdata_nx;
            mem_rd      <= rd_nx;
            mem_wr      <= wr_nx;
            rsp_valid   <= rsp_nx;
            rsp_rdata   <= rdata_nx;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed table, corner sequences and
// random traffic against a transaction-level timing model.
module tb_memory_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int L    = 3;
    localparam int IW   = $clog2(NREQ);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [NREQ-1:0] req_valid, req_ready, req_wr, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0] rsp_rdata, mem_wr_data, mem_data_in;
    logic [AW-1:0] mem_addr;
    logic mem_rd, mem_wr;
    logic [IW-1:0] grant_id;

    logic pend_v [NREQ];
    logic pend_wr [NREQ];
    logic [15:0] pend_a [NREQ];
    logic [15:0] pend_d [NREQ];

    logic [15:0] tmem [0:65535];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]           = pend_v[i];
            req_wr[i]              = pend_wr[i];
            req_addr[i*AW +: AW]   = pend_a[i];
            req_wdata[i*DW +: DW]  = pend_d[i];
        end
    end

    assign mem_data_in = mem_wr ? mem_wr_data : tmem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr) tmem[mem_addr] <= mem_wr_data;
    end

    memory_arbiter #(
        .NREQ   (NREQ),
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (L)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_data_in (mem_data_in),
        .grant_id    (grant_id)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction-level model: one job in flight, k = cycles since accept.
    logic m_act = 1'b0;
    int m_k = 0;
    int m_g = 0;
    int m_ptr = NREQ - 1;
    int m_gid = 0;
    logic m_wr = 1'b0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_wdata = '0;
    logic [15:0] m_rdata = '0;

    function automatic int pick();
        for (int j = 1; j <= NREQ; j++) begin
            if (pend_v[(m_ptr + j) % NREQ]) return (m_ptr + j) % NREQ;
        end
        return -1;
    endfunction

    function automatic int last_k();
        return m_wr ? 2 : L + 1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_act   <= 1'b0;
            m_k     <= 0;
            m_ptr   <= NREQ - 1;
            m_gid   <= 0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_rdata <= '0;
        end else if (m_act) begin
            if (m_k == last_k()) begin
                m_act <= 1'b0;
            end else begin
                if (!m_wr && m_k == L) m_rdata <= tmem[m_addr];
                m_k <= m_k + 1;
            end
        end else if (pick() >= 0) begin
            m_act   <= 1'b1;
            m_k     <= 1;
            m_g     <= pick();
            m_gid   <= pick();
            m_ptr   <= pick();
            m_wr    <= pend_wr[pick()];
            m_addr  <= pend_a[pick()];
            m_wdata <= pend_d[pick()];
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] e_rdy, e_rsp;
        logic e_rd, e_wr;
        e_rdy = '0;
        e_rsp = '0;
        if (!m_act && pick() >= 0) e_rdy[pick()] = 1'b1;
        e_rd = m_act && !m_wr && m_k >= 1 && m_k <= L;
        e_wr = m_act && m_wr && m_k == 1;
        if (m_act && m_k == last_k()) e_rsp[m_g] = 1'b1;
        chk("cycle",
            64'({req_ready, rsp_valid, rsp_rdata, mem_addr,
                 mem_wr_data, mem_rd, mem_wr, grant_id}),
            64'({e_rdy, e_rsp, m_rdata, m_addr,
                 m_wdata, e_rd, e_wr, IW'(m_gid)}));
    end

    typedef struct {
        int          r;
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] exp_rdata;
    } vec_t;

    task automatic txn(input int r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, output int lat,
                       output int rdcnt, output logic [15:0] rdata,
                       output int gid);
        logic acc;
        acc = 1'b0;
        lat = 0;
        rdcnt = 0;
        rdata = 'x;
        gid = -1;
        pend_v[r] = 1'b1;
        pend_wr[r] = w;
        pend_a[r] = a;
        pend_d[r] = d;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            if (req_ready[r]) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        pend_v[r] = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (mem_rd) rdcnt++;
            if (rsp_valid[r]) begin
                lat = t;
                rdata = rsp_rdata;
                gid = int'(grant_id);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("rsp_timeout", 0, 1);
    endtask

    vec_t tbl [7];

    initial begin
        int lat, rdcnt, gid, n;
        logic [15:0] rd;
        logic [NREQ-1:0] rdy;
        logic order [4];

        for (int i = 0; i < 65536; i++) tmem[i] = '0;
        tmem[16'hFFFF] = 16'h1234;
        for (int i = 0; i < NREQ; i++) begin
            pend_v[i] = 1'b0;
            pend_wr[i] = 1'b0;
            pend_a[i] = '0;
            pend_d[i] = '0;
        end

        tbl[0] = '{0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
        tbl[1] = '{0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        tbl[2] = '{0, 1'b0, 16'hFFFF, 16'h0000, 16'h1234};
        tbl[3] = '{0, 1'b1, 16'h0000, 16'hA5A5, 16'h1234};
        tbl[4] = '{1, 1'b0, 16'h0000, 16'h0000, 16'hA5A5};
        tbl[5] = '{1, 1'b1, 16'hFFFF, 16'h0F0F, 16'hA5A5};
        tbl[6] = '{1, 1'b0, 16'hFFFF, 16'h0000, 16'h0F0F};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            64'({req_ready, rsp_valid, rsp_rdata, mem_addr,
                 mem_wr_data, mem_rd, mem_wr, grant_id}), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            txn(tbl[i].r, tbl[i].wr, tbl[i].a, tbl[i].d,
                lat, rdcnt, rd, gid);
            chk("latency", lat, tbl[i].wr ? 2 : L + 1);
            chk("rd_cycles", rdcnt, tbl[i].wr ? 0 : L);
            chk("grant", gid, tbl[i].r);
            chk("rdata", rd, tbl[i].exp_rdata);
            if (tbl[i].wr) chk("mem_written", tmem[tbl[i].a], tbl[i].d);
        end

        // Reset in the middle of a read by req0.
        pend_v[0] = 1'b1;
        pend_wr[0] = 1'b0;
        pend_a[0] = 16'h0010;
        @(negedge clk);
        chk("mid_accept", req_ready, 2'b01);
        @(posedge clk);
        #1;
        pend_v[0] = 1'b0;
        @(negedge clk);
        chk("mid_rd_high", mem_rd, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_reset_clear",
            64'({req_ready, rsp_valid, rsp_rdata, mem_addr,
                 mem_wr_data, mem_rd, mem_wr, grant_id}), 0);
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b1;
        n = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (rsp_valid != 0) n++;
        end
        chk("no_rsp_after_reset", n, 0);
        @(posedge clk);
        #1;

        // Contention: both requesters hold reads continuously.
        pend_v[0] = 1'b1;
        pend_wr[0] = 1'b0;
        pend_a[0] = 16'h0010;
        pend_v[1] = 1'b1;
        pend_wr[1] = 1'b0;
        pend_a[1] = 16'hFFFF;
        n = 0;
        for (int t = 0; t < 40 && n < 4; t++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                order[n] = req_ready[1];
                n++;
            end
            @(posedge clk);
            #1;
        end
        pend_v[0] = 1'b0;
        pend_v[1] = 1'b0;
        chk("contention_count", n, 4);
        for (int i = 0; i < 4; i++) chk("grant_order", order[i], i % 2);

        // Random traffic, checked every cycle by the model.
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (rdy[i]) pend_v[i] = 1'b0;
                if (!pend_v[i] && $urandom_range(0, 2) == 0) begin
                    pend_v[i] = 1'b1;
                    pend_wr[i] = 1'($urandom_range(0, 1));
                    case ($urandom_range(0, 3))
                        0: pend_a[i] = 16'h0000;
                        1: pend_a[i] = 16'hFFFF;
                        default: pend_a[i] = 16'($urandom_range(0, 7));
                    endcase
                    pend_d[i] = 16'($urandom);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sequencing controller and round-robin arbiter that shares one 16-bit single-port memory (shared bidirectional data bus, `addr`, `rd`, `wr`) among `NREQ` requesters. Each requester issues read or write transactions over a valid/ready request port and receives a one-cycle response pulse. The block drives the memory's tester-side signals (write-data register, address, `rd`, `wr`) and samples the resolved data bus for reads. It sits between the testbench/agents or internal masters and the memory model.

## Interface
- `NREQ`, 2: number of requesters, 2..8.
- `AW`, 16: address width.
- `DW`, 16: data width.
- `RD_LAT`, 1: number of cycles `mem_rd` is held before read data is sampled, 1..15.

- `clk`  in  1  rising-edge clock (single clock domain).
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_ready`  out  NREQ  accept strobe, at most one bit set.
- `req_wr`  in  NREQ  1 = write, 0 = read, per requester.
- `req_addr`  in  NREQ*AW  packed addresses; requester i occupies `[i*AW +: AW]`.
- `req_wdata`  in  NREQ*DW  packed write data, same packing.
- `rsp_valid`  out  NREQ  one-cycle completion pulse to the owning requester.
- `rsp_rdata`  out  DW  read data, valid with `rsp_valid`.
- `mem_addr`  out  AW  memory address.
- `mem_wr_data`  out  DW  drives the memory's write-data register.
- `mem_rd`  out  1  memory read strobe.
- `mem_wr`  out  1  memory write strobe; the bus is driven from `mem_wr_data` while this is high.
- `mem_data_in`  in  DW  resolved shared data bus.
- `grant_id`  out  $clog2(NREQ)  index of the current or last granted requester.

## Operation
- The FSM has four states: IDLE, WR, RD, RSP.
- **IDLE:**
  - If any `req_valid` is high, the round-robin pick g is made.
  - `req_ready[g]` is asserted combinationally in the same cycle.
  - On that edge: latch `req_addr[g]`, `req_wdata[g]` and `req_wr[g]`; set `grant_id`=g and the pointer to g.
  - Next state is WR if `req_wr[g]`=1, otherwise RD.
- **WR:** `mem_wr`=1 with the latched addr/data for exactly one cycle, then RSP.
- **RD:**
  - `mem_rd`=1 with the latched addr for `RD_LAT` consecutive cycles, counted by a 4-bit counter.
  - On the edge ending the last RD cycle, capture `mem_data_in` into `rsp_rdata`, then RSP.
- **RSP:** `rsp_valid[g]`=1 for one cycle, then IDLE. There is no response backpressure.
- **Round-robin:**
  - Search starts at pointer+1 modulo NREQ.
  - Pointer updates only on accept.
  - Reset pointer = NREQ-1, so requester 0 wins first.
- **Requester rule:** `req_valid` and its payload are held stable until `req_ready`. The arbiter never accepts outside IDLE.
- **Invariants:**
  - `mem_rd` and `mem_wr` are never high together.
  - `req_ready` and `rsp_valid` are each one-hot or zero.
- **Response data:** `rsp_rdata` is unchanged by writes and holds the last read value.
- **Address range:** 0x0000 and 0xFFFF pass through unmodified; there is no address arithmetic.

## Timing
- **Reset state:**
  - All outputs are 0: `req_ready`, `rsp_valid`, `rsp_rdata`, `mem_addr`, `mem_wr_data`, `mem_rd`, `mem_wr`, `grant_id`.
  - State = IDLE, pointer = NREQ-1.
- **Registered outputs:** `mem_*`, `rsp_*` and `grant_id` are registered. `req_ready` is a combinational decode of registered state plus `req_valid`.
- **Write latency:** accept in cycle 0, `mem_wr` in cycle 1, `rsp_valid` in cycle 2. Next accept is possible in cycle 3, giving 3 cycles per write.
- **Read latency:** accept in cycle 0, `mem_rd` in cycles 1..RD_LAT, `rsp_valid` in cycle RD_LAT+1. Total is RD_LAT+2 cycles per read.
- **Reset assertion mid-transaction:**
  - Outputs clear immediately (asynchronously) and the transaction is dropped with no `rsp_valid`.
  - After deassertion the arbiter restarts from IDLE with requester 0 favoured.
- **Deasserted request:** a `req_valid` that drops before accept is a requester protocol error. The arbiter does not need to detect it.

## Structure
- Package `mem_arb_pkg` holds:
  - typedef enum `arb_state_t` {IDLE, WR, RD, RSP};
  - localparams `MEM_AW`=16 and `MEM_DW`=16;
  - typedef `mem_word_t` = logic[15:0].
- Sub-module `rr_arbiter`: combinational one-hot pick from request vector + pointer, parameterised by NREQ. The pointer register lives in `memory_arbiter`.

## Test plan
- **Single write then read:** req0 writes addr 0x0010, data 0xBEEF, then reads 0x0010.
  - Write: `mem_wr` high for 1 cycle with addr 0x0010, data 0xBEEF.
  - Read: `rsp_valid[0]` arrives at cycle RD_LAT+1 with `rsp_rdata`=0xBEEF.
- **Contention:** req0 and req1 both hold valid reads from reset.
  - Grant order: 0, 1, 0, 1.
  - `grant_id` alternates and no requester waits more than one transaction.
- **RD_LAT=3:** a read of 0xFFFF holds `mem_rd` for exactly 3 cycles, `rsp_valid` arrives at cycle 4, and data matches the preloaded value 0x1234.
- **Reset mid-read:** reset asserted during RD.
  - All outputs are 0 immediately and no `rsp_valid` follows.
  - The first post-reset grant goes to req0.
- **Interleaved mixed traffic:** req0 writes 0xA5A5 to 0x0000; req1 then reads 0x0000.
  - req1 receives 0xA5A5.
  - `mem_rd` and `mem_wr` are never simultaneously high.
  - `rsp_rdata` is unchanged during the write's RSP cycle.
